fmdll_lock_ctrl: RTL

//  Configuration and lock sequencer for the FMDLL core. Accepts an M/N multiply

---
 rtl/fmdll_pkg.sv | 29 ++
 rtl/fmdll_lock_ctrl_if.sv | 14 +
 rtl/fmdll_lock_filter.sv | 55 +++++
 rtl/fmdll_lock_ctrl.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/fmdll_pkg.sv
// Shared types, constants and the M/N legality check for the FMDLL lock controller.
`timescale 1ns/1ps
package fmdll_pkg;

  localparam int unsigned M_W   = 2;
  localparam int unsigned N_W   = 4;
  localparam int unsigned SEL_W = 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RST    = 3'd1,
    WAIT   = 3'd2,
    CHECK  = 3'd3,
    LOCKED = 3'd4,
    FAIL   = 3'd5
  } state_e;

  localparam logic [SEL_W-1:0] SEL_MAX = 2'd3;
  localparam logic [M_W-1:0]   M_DEF   = 2'd1;
  localparam logic [N_W-1:0]   N_DEF   = 4'd1;

  // M in {1,2,3}, N in {1,4,5,8,10}
  function automatic logic is_legal_mn(input logic [M_W-1:0] m, input logic [N_W-1:0] n);
    logic n_ok;
    n_ok = (n == 4'd1) || (n == 4'd4) || (n == 4'd5) || (n == 4'd8) || (n == 4'd10);
    return (m != 2'd0) && n_ok;
  endfunction

endpackage

// File: rtl/fmdll_lock_ctrl_if.sv
// Config request bus between the system config master and the lock controller.
`timescale 1ns/1ps
interface fmdll_lock_ctrl_if;
  import fmdll_pkg::*;

  logic           cfg_valid;
  logic           cfg_ready;
  logic [M_W-1:0] cfg_m;
  logic [N_W-1:0] cfg_n;
  logic           cfg_err;

  modport master (output cfg_valid, cfg_m, cfg_n, input cfg_ready, cfg_err);
  modport slave  (input cfg_valid, cfg_m, cfg_n, output cfg_ready, cfg_err);
endinterface

// File: rtl/fmdll_lock_filter.sv
// Lock indicator conditioning: 2-FF synchronizer plus consecutive-high and
// consecutive-low run counters. i_clr restarts both runs (used on state change).
`timescale 1ns/1ps
module fmdll_lock_filter #(
  parameter int unsigned LOCK_CNT = 32,
  parameter int unsigned LOSS_CYC = 4,
  parameter int unsigned CNT_W    = 10
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_lock,
  input  logic i_clr,
  output logic o_lock_sync,
  output logic o_lock_stable,
  output logic o_lock_lost
);

  localparam logic [CNT_W-1:0] HI_MAX = CNT_W'(LOCK_CNT);
  localparam logic [CNT_W-1:0] LO_MAX = CNT_W'(LOSS_CYC);

  logic             r_meta;
  logic             r_sync;
  logic [CNT_W-1:0] r_hi_cnt;
  logic [CNT_W-1:0] r_lo_cnt;

  // Bring the asynchronous lock indicator into the clk_ext domain
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_lock;
      r_sync <= r_meta;
    end
  end

  // Saturating run-length counters of the synchronized indicator
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_hi_cnt <= '0;
      r_lo_cnt <= '0;
    end else if (r_sync) begin
      r_lo_cnt <= '0;
      if (r_hi_cnt != HI_MAX) r_hi_cnt <= r_hi_cnt + CNT_W'(1);
    end else begin
      r_hi_cnt <= '0;
      if (r_lo_cnt != LO_MAX) r_lo_cnt <= r_lo_cnt + CNT_W'(1);
    end
  end

  assign o_lock_sync   = r_sync;
  assign o_lock_stable = (r_hi_cnt == HI_MAX);
  assign o_lock_lost   = (r_lo_cnt == LO_MAX);

endmodule

// File: rtl/fmdll_lock_ctrl.sv
// FMDLL configuration and band-search lock sequencer (clk_ext domain).
// Optional build macro FMDLL_AUTO_RELOCK_EN: lock loss restarts the band
// search instead of parking in FAIL.
`timescale 1ns/1ps
module fmdll_lock_ctrl
  import fmdll_pkg::*;
#(
  parameter int unsigned RST_CYC    = 16,
  parameter int unsigned SETTLE_CYC = 256,
  parameter int unsigned LOCK_CNT   = 32,
  parameter int unsigned LOSS_CYC   = 4,
  parameter int unsigned CNT_W      = 10
) (
  input  logic                 i_clk_ext,
  input  logic                 i_rst,
  fmdll_lock_ctrl_if.slave     cfg_if,
  input  logic                 i_dll_lock,
  output logic [M_W-1:0]       o_dll_m,
  output logic [N_W-1:0]       o_dll_n,
  output logic                 o_dll_rst_n,
  output logic [SEL_W-1:0]     o_sel,
  output logic                 o_locked,
  output logic                 o_fail
);

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);

  state_e           r_state;
  state_e           w_next;
  logic [CNT_W-1:0] r_cnt;

  logic [M_W-1:0]   r_dll_m,     w_dll_m_d;
  logic [N_W-1:0]   r_dll_n,     w_dll_n_d;
  logic [SEL_W-1:0] r_sel,       w_sel_d;
  logic             r_dll_rst_n, w_dll_rst_n_d;
  logic             r_locked,    w_locked_d;
  logic             r_fail,      w_fail_d;
  logic             r_cfg_ready, w_cfg_ready_d;
  logic             r_cfg_err,   w_cfg_err_d;

  logic w_hs, w_hs_ok, w_hs_bad, w_state_chg;
  logic w_lock_sync, w_lock_stable, w_lock_lost;

  assign w_hs        = cfg_if.cfg_valid & r_cfg_ready;
  assign w_hs_ok     = w_hs & is_legal_mn(cfg_if.cfg_m, cfg_if.cfg_n);
  assign w_hs_bad    = w_hs & ~is_legal_mn(cfg_if.cfg_m, cfg_if.cfg_n);
  assign w_state_chg = (w_next != r_state);

  fmdll_lock_filter #(
    .LOCK_CNT (LOCK_CNT),
    .LOSS_CYC (LOSS_CYC),
    .CNT_W    (CNT_W)
  ) u_filter (
    .i_clk         (i_clk_ext),
    .i_rst         (i_rst),
    .i_lock        (i_dll_lock),
    .i_clr         (w_state_chg),
    .o_lock_sync   (w_lock_sync),
    .o_lock_stable (w_lock_stable),
    .o_lock_lost   (w_lock_lost)
  );

  // State register and shared phase counter (restarts on every state change)
  always_ff @(posedge i_clk_ext) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_state_chg)                           r_cnt <= '0;
      else if (r_state == RST || r_state == WAIT) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Next-state decision
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, FAIL: if (w_hs_ok) w_next = RST;
      RST:        if (r_cnt == RST_LAST) w_next = WAIT;
      WAIT:       if (r_cnt == SETTLE_LAST) w_next = CHECK;
      CHECK: begin
        if (w_lock_stable)          w_next = LOCKED;
        else if (!w_lock_sync)      w_next = (r_sel == SEL_MAX) ? FAIL : RST;
      end
      LOCKED: begin
        if (w_hs_ok)                w_next = RST;
`ifdef FMDLL_AUTO_RELOCK_EN
        else if (w_lock_lost)       w_next = RST;
`else
        else if (w_lock_lost)       w_next = FAIL;
`endif
      end
      default:                      w_next = IDLE;
    endcase
  end

  // Next output values, derived from the transition being taken
  always_comb begin
    w_dll_m_d     = r_dll_m;
    w_dll_n_d     = r_dll_n;
    w_sel_d       = r_sel;
    w_dll_rst_n_d = r_dll_rst_n;
    w_locked_d    = (w_next == LOCKED);
    w_fail_d      = (w_next == FAIL);
    w_cfg_ready_d = (w_next == IDLE) || (w_next == LOCKED) || (w_next == FAIL);
    w_cfg_err_d   = w_hs_bad;
    if (w_hs_ok) begin
      w_dll_m_d = cfg_if.cfg_m;
      w_dll_n_d = cfg_if.cfg_n;
    end
    case (w_next)
      RST:                 w_dll_rst_n_d = 1'b0;
      WAIT, CHECK, LOCKED: w_dll_rst_n_d = 1'b1;
      default:             ;
    endcase
    // Entering RST: next band after a failed check, otherwise a fresh search from band 0
    if (w_state_chg && (w_next == RST)) begin
      if (r_state == CHECK) w_sel_d = r_sel + SEL_W'(1);
      else                  w_sel_d = '0;
    end
  end

  // Output registers
  always_ff @(posedge i_clk_ext) begin
    if (i_rst) begin
      r_dll_m     <= M_DEF;
      r_dll_n     <= N_DEF;
      r_sel       <= '0;
      r_dll_rst_n <= 1'b0;
      r_locked    <= 1'b0;
      r_fail      <= 1'b0;
      r_cfg_ready <= 1'b0;
      r_cfg_err   <= 1'b0;
    end else begin
      r_dll_m     <= w_dll_m_d;
      r_dll_n     <= w_dll_n_d;
      r_sel       <= w_sel_d;
      r_dll_rst_n <= w_dll_rst_n_d;
      r_locked    <= w_locked_d;
      r_fail      <= w_fail_d;
      r_cfg_ready <= w_cfg_ready_d;
      r_cfg_err   <= w_cfg_err_d;
    end
  end

  assign cfg_if.cfg_ready = r_cfg_ready;
  assign cfg_if.cfg_err   = r_cfg_err;
  assign o_dll_m          = r_dll_m;
  assign o_dll_n          = r_dll_n;
  assign o_dll_rst_n      = r_dll_rst_n;
  assign o_sel            = r_sel;
  assign o_locked         = r_locked;
  assign o_fail           = r_fail;

endmodule
